// File: rtl/titan_defines.sv
// Shared definitions for the titan load/store unit.
//   - lsu_state_e : FSM encoding (IDLE/BUSY/DONE/ABORT = 0..3)
//   - lsu_size_e  : decoded access size
//   - WB_SEL_*    : Wishbone byte-select patterns
//   - decode_size : size-flag priority decode (word > half > byte)
`timescale 1ns/1ps
package titan_defines;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ABORT = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } lsu_size_e;

  localparam logic [3:0] WB_SEL_NONE    = 4'b0000;
  localparam logic [3:0] WB_SEL_BYTE    = 4'b0001;
  localparam logic [3:0] WB_SEL_HALF_LO = 4'b0011;
  localparam logic [3:0] WB_SEL_HALF_HI = 4'b1100;
  localparam logic [3:0] WB_SEL_WORD    = 4'b1111;

  // Several size flags may be set at once; the widest one wins.
  function automatic lsu_size_e decode_size(input logic i_b, input logic i_h, input logic i_w);
    lsu_size_e r;
    if (i_w)      r = SZ_WORD;
    else if (i_h) r = SZ_HALF;
    else if (i_b) r = SZ_BYTE;
    else          r = SZ_NONE;
    return r;
  endfunction

endpackage

// File: rtl/titan_lsu_align.sv
// Combinational lane logic for the load/store unit.
// Store side: byte selects and lane-replicated write data from the live request.
// Load side : lane extraction and sign/zero extension of the bus read data,
//             using the size/offset captured when the access was issued.
// Ports:
//   i_st_off/i_st_size/i_st_data -> o_sel, o_wdat
//   i_ld_off/i_ld_size/i_ld_unsigned/i_rdata -> o_ldata
`timescale 1ns/1ps
module titan_lsu_align
  import titan_defines::*;
(
  input  logic [1:0]  i_st_off,
  input  lsu_size_e   i_st_size,
  input  logic [31:0] i_st_data,
  output logic [3:0]  o_sel,
  output logic [31:0] o_wdat,
  input  logic [1:0]  i_ld_off,
  input  lsu_size_e   i_ld_size,
  input  logic        i_ld_unsigned,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ldata
);

  function automatic logic [31:0] ext_byte(input logic [7:0] v, input logic uns);
    logic signed [7:0] sv;
    sv = v;
    return uns ? {24'h0, v} : 32'(sv);
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] v, input logic uns);
    logic signed [15:0] sv;
    sv = v;
    return uns ? {16'h0, v} : 32'(sv);
  endfunction

  logic [7:0]  w_lb;
  logic [15:0] w_lh;

  always_comb begin
    o_sel  = WB_SEL_NONE;
    o_wdat = i_st_data;
    case (i_st_size)
      SZ_BYTE: begin
        o_sel  = WB_SEL_BYTE << i_st_off;
        o_wdat = {4{i_st_data[7:0]}};
      end
      SZ_HALF: begin
        o_sel  = i_st_off[1] ? WB_SEL_HALF_HI : WB_SEL_HALF_LO;
        o_wdat = {2{i_st_data[15:0]}};
      end
      SZ_WORD: o_sel = WB_SEL_WORD;
      default: ;
    endcase
  end

  always_comb begin
    case (i_ld_off)
      2'd0:    w_lb = i_rdata[7:0];
      2'd1:    w_lb = i_rdata[15:8];
      2'd2:    w_lb = i_rdata[23:16];
      default: w_lb = i_rdata[31:24];
    endcase
    w_lh = i_ld_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_ld_size)
      SZ_BYTE: o_ldata = ext_byte(w_lb, i_ld_unsigned);
      SZ_HALF: o_ldata = ext_half(w_lh, i_ld_unsigned);
      default: o_ldata = i_rdata;
    endcase
  end

endmodule

// File: rtl/titan_lsu.sv
// Load/store unit beside the MEM stage: converts one MEM-stage access into a single
// Wishbone B4 classic master cycle (one outstanding access at most).
// Ports:
//   clk_i, rst_i (async, active-low)
//   lsu_*_i : request flags, address, store data, stall/kill from the pipeline
//   lsu_data_o/lsu_cyc_o/lsu_ack_o/lsu_err_o : result and handshake to the MEM stage
//   wb_*    : Wishbone classic master port
`timescale 1ns/1ps
module titan_lsu
  import titan_defines::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
)(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic        lsu_mread_i,
  input  logic        lsu_mwrite_i,
  input  logic        lsu_mbyte_i,
  input  logic        lsu_mhw_i,
  input  logic        lsu_mword_i,
  input  logic        lsu_munsigned_i,
  input  logic        lsu_stall_i,
  input  logic        lsu_kill_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_cyc_o,
  output logic        lsu_ack_o,
  output logic        lsu_err_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  lsu_state_e       r_state, w_state_nxt;
  logic [31:0]      r_adr, r_dat, r_data;
  logic [3:0]       r_sel;
  logic             r_we, r_uns, r_err;
  logic [1:0]       r_off;
  lsu_size_e        r_size;
  logic [CNT_W-1:0] r_cnt;

  lsu_size_e   w_size;
  logic        w_misaligned, w_req, w_bus, w_timeout, w_bus_end, w_start;
  logic [3:0]  w_sel;
  logic [31:0] w_wdat, w_ldata;

  assign w_size       = decode_size(lsu_mbyte_i, lsu_mhw_i, lsu_mword_i);
  assign w_misaligned = ((w_size == SZ_WORD) && (lsu_addr_i[1:0] != 2'b00)) ||
                        ((w_size == SZ_HALF) && lsu_addr_i[0]);
  assign w_req        = (lsu_mread_i | lsu_mwrite_i) & ~w_misaligned & ~lsu_kill_i;
  assign w_start      = (r_state == ST_IDLE) && w_req;

  assign w_bus     = (r_state == ST_BUSY) || (r_state == ST_ABORT);
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_bus_end = wb_ack_i | wb_err_i | w_timeout;

  titan_lsu_align u_align (
    .i_st_off      (lsu_addr_i[1:0]),
    .i_st_size     (w_size),
    .i_st_data     (lsu_wdata_i),
    .o_sel         (w_sel),
    .o_wdat        (w_wdat),
    .i_ld_off      (r_off),
    .i_ld_size     (r_size),
    .i_ld_unsigned (r_uns),
    .i_rdata       (wb_dat_i),
    .o_ldata       (w_ldata)
  );

  // Next-state decode. A kill that coincides with the bus response retires the
  // access silently; a kill without it must wait out the slave in ABORT.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_req) w_state_nxt = ST_BUSY;
      ST_BUSY: begin
        if (w_bus_end)       w_state_nxt = lsu_kill_i ? ST_IDLE : ST_DONE;
        else if (lsu_kill_i) w_state_nxt = ST_ABORT;
      end
      ST_DONE:  if (~lsu_stall_i | lsu_kill_i) w_state_nxt = ST_IDLE;
      ST_ABORT: if (w_bus_end) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Request capture: the bus-facing registers are loaded on the accepting edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_adr  <= '0;
      r_dat  <= '0;
      r_sel  <= '0;
      r_we   <= 1'b0;
      r_off  <= '0;
      r_size <= SZ_NONE;
      r_uns  <= 1'b0;
    end else if (w_start) begin
      r_adr  <= {lsu_addr_i[31:2], 2'b00};
      r_dat  <= w_wdat;
      r_sel  <= w_sel;
      r_we   <= lsu_mwrite_i;
      r_off  <= lsu_addr_i[1:0];
      r_size <= w_size;
      r_uns  <= lsu_munsigned_i;
    end
  end

  // Timeout counter: restarts on entry to BUSY and again on entry to ABORT, saturates.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
    end else if (((w_state_nxt == ST_BUSY) && (r_state != ST_BUSY)) ||
                 ((w_state_nxt == ST_ABORT) && (r_state != ST_ABORT))) begin
      r_cnt <= '0;
    end else if (w_bus && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Result capture on BUSY -> DONE. Errors and timeouts return zero data.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_data <= '0;
      r_err  <= 1'b0;
    end else if ((r_state == ST_BUSY) && (w_state_nxt == ST_DONE)) begin
      if (wb_ack_i) begin
        r_data <= w_ldata;
        r_err  <= 1'b0;
      end else begin
        r_data <= '0;
        r_err  <= 1'b1;
      end
    end
  end

  assign wb_cyc_o = w_bus;
  assign wb_stb_o = w_bus;
  assign wb_adr_o = r_adr;
  assign wb_dat_o = r_dat;
  assign wb_sel_o = w_bus ? r_sel : WB_SEL_NONE;
  assign wb_we_o  = w_bus & r_we;

  assign lsu_cyc_o  = w_start || (r_state == ST_BUSY) || (r_state == ST_DONE);
  assign lsu_ack_o  = (r_state == ST_DONE);
  assign lsu_err_o  = (r_state == ST_DONE) & r_err;
  assign lsu_data_o = r_data;

endmodule

// File: tb/tb_titan_lsu.sv
`timescale 1ns/1ps
module tb_titan_lsu;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic        lsu_mread_i, lsu_mwrite_i, lsu_mbyte_i, lsu_mhw_i, lsu_mword_i;
  logic        lsu_munsigned_i, lsu_stall_i, lsu_kill_i;
  logic [31:0] lsu_data_o;
  logic        lsu_cyc_o, lsu_ack_o, lsu_err_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i, wb_err_i;

  titan_lsu #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_mread_i(lsu_mread_i), .lsu_mwrite_i(lsu_mwrite_i),
    .lsu_mbyte_i(lsu_mbyte_i), .lsu_mhw_i(lsu_mhw_i), .lsu_mword_i(lsu_mword_i),
    .lsu_munsigned_i(lsu_munsigned_i), .lsu_stall_i(lsu_stall_i), .lsu_kill_i(lsu_kill_i),
    .lsu_data_o(lsu_data_o), .lsu_cyc_o(lsu_cyc_o), .lsu_ack_o(lsu_ack_o), .lsu_err_o(lsu_err_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  always #5 clk_i = ~clk_i;

  int n_pass = 0;
  int n_total = 0;

  // Expected outputs for the current cycle, maintained by the stimulus process.
  bit          chk_en = 1'b0;
  bit          e_wbcyc, e_lcyc, e_ack, e_err, e_we;
  logic [31:0] e_adr, e_dat, e_data;
  logic [3:0]  e_sel;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  function automatic int acc_bytes(input bit b, input bit h, input bit w);
    if (w) return 4;
    if (h) return 2;
    if (b) return 1;
    return 0;
  endfunction

  function automatic int lane_base(input logic [31:0] a, input int n);
    int off;
    off = int'(a % 4);
    return off - (off % n);
  endfunction

  function automatic logic [3:0] m_sel(input logic [31:0] a, input int n);
    logic [3:0] s;
    int base;
    s = 4'b0000;
    base = lane_base(a, n);
    for (int j = 0; j < n; j++) s[base + j] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] m_wdat(input logic [31:0] wd, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] mem, input logic [31:0] a,
                                         input int n, input bit uns);
    logic [31:0] v, mask;
    v = mem >> (8 * lane_base(a, n));
    if (n < 4) begin
      mask = (32'h1 << (8 * n)) - 32'h1;
      v = v & mask;
      if (!uns && v[8*n-1]) v = v | ~mask;
    end
    return v;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("wb_cyc", wb_cyc_o, e_wbcyc);
      chk("wb_stb", wb_stb_o, e_wbcyc);
      chk("lsu_cyc", lsu_cyc_o, e_lcyc);
      chk("lsu_ack", lsu_ack_o, e_ack);
      chk("lsu_err", lsu_err_o, e_ack & e_err);
      if (e_wbcyc) begin
        chk("wb_adr", wb_adr_o, e_adr);
        chk("wb_sel", wb_sel_o, e_sel);
        chk("wb_we", wb_we_o, e_we);
        if (e_we) chk("wb_dat", wb_dat_o, e_dat);
      end else begin
        chk("wb_sel_idle", wb_sel_o, 4'b0000);
      end
      if (e_ack) chk("lsu_data", lsu_data_o, e_data);
    end
  end

  task automatic set_idle();
    e_wbcyc = 0; e_lcyc = 0; e_ack = 0; e_err = 0;
  endtask

  // One MEM-stage access. resp_at: BUSY/ABORT cycle index of the slave response (-1 none).
  // kill_at: cycle index of the bus phase in which kill is raised (-1 none, -2 with the request).
  task automatic run_access(input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] mem,
                            input bit rd, input bit wr, input bit b, input bit h, input bit w,
                            input bit uns, input int resp_at, input bit resp_err,
                            input int stall_n, input int kill_at);
    int  n, g, k;
    bit  mis, req, aborting, fin, resp, to, kl, got_done, err_res;
    n = acc_bytes(b, h, w);
    mis = (n != 0) && ((int'(addr % 4) % n) != 0);
    req = (rd || wr) && !mis && (kill_at != -2);
    @(posedge clk_i); #1;
    lsu_addr_i = addr; lsu_wdata_i = wd; lsu_mread_i = rd; lsu_mwrite_i = wr;
    lsu_mbyte_i = b; lsu_mhw_i = h; lsu_mword_i = w; lsu_munsigned_i = uns;
    lsu_kill_i = (kill_at == -2);
    e_wbcyc = 0; e_lcyc = req; e_ack = 0; e_err = 0;
    e_adr = addr & ~32'd3;
    e_sel = (n == 0) ? 4'b0000 : m_sel(addr, n);
    e_dat = (n == 0) ? wd : m_wdat(wd, n);
    e_we  = wr;
    @(posedge clk_i); #1;
    lsu_mread_i = 0; lsu_mwrite_i = 0; lsu_kill_i = 0;
    if (!req) begin
      set_idle();
      return;
    end
    g = 0; k = 0; aborting = 0; fin = 0; got_done = 0; err_res = 0;
    while (!fin && g < 100) begin
      e_wbcyc = 1; e_lcyc = !aborting; e_ack = 0;
      resp = (g == resp_at);
      to   = (k == 15);
      kl   = !aborting && (g == kill_at);
      wb_ack_i = resp && !resp_err;
      wb_err_i = resp && resp_err;
      wb_dat_i = resp ? mem : $urandom;
      lsu_kill_i = kl;
      @(posedge clk_i); #1;
      wb_ack_i = 0; wb_err_i = 0; lsu_kill_i = 0; wb_dat_i = $urandom;
      if (resp || to) begin
        fin = 1;
        got_done = !aborting && !kl;
        err_res = !resp || resp_err;
      end else if (kl) begin
        aborting = 1;
        k = 0;
      end else begin
        k++;
      end
      g++;
    end
    if (!fin) begin
      n_total++;
      $display("FAIL bus_phase_bound: still in bus phase after %0d cycles, expected end by 32", g);
    end
    if (got_done) begin
      for (int i = 0; i <= stall_n; i++) begin
        e_wbcyc = 0; e_lcyc = 1; e_ack = 1; e_err = err_res;
        e_data = err_res ? 32'h0 : m_load(mem, addr, (n == 0) ? 4 : n, uns);
        lsu_stall_i = (i < stall_n);
        @(posedge clk_i); #1;
      end
      lsu_stall_i = 0;
    end
    set_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] sz;
    int op, r, kr, resp_at, kill_at;
    rst_i = 0;
    lsu_addr_i = 0; lsu_wdata_i = 0; lsu_mread_i = 0; lsu_mwrite_i = 0;
    lsu_mbyte_i = 0; lsu_mhw_i = 0; lsu_mword_i = 0; lsu_munsigned_i = 0;
    lsu_stall_i = 0; lsu_kill_i = 0; wb_dat_i = 0; wb_ack_i = 0; wb_err_i = 0;
    set_idle(); e_we = 0; e_adr = 0; e_dat = 0; e_data = 0; e_sel = 0;

    // Model pins: hand-computed values.
    chk("pin_lb_data", m_load(32'h80FF1234, 32'h1003, 1, 0), 32'hFFFF_FF80);
    chk("pin_lb_sel", m_sel(32'h1003, 1), 4'b1000);
    chk("pin_lhu_data", m_load(32'h80FF1234, 32'h2002, 2, 1), 32'h0000_80FF);
    chk("pin_lhu_sel", m_sel(32'h2002, 2), 4'b1100);
    chk("pin_sb_dat", m_wdat(32'h0000_00AB, 1), 32'hABAB_ABAB);
    chk("pin_sb_sel", m_sel(32'h3001, 1), 4'b0010);
    chk("pin_lh_signed", m_load(32'h1234_8001, 32'h0, 2, 0), 32'hFFFF_8001);

    // Reset state.
    #23;
    chk("rst_wb_cyc", wb_cyc_o, 0);
    chk("rst_wb_stb", wb_stb_o, 0);
    chk("rst_wb_sel", wb_sel_o, 0);
    chk("rst_wb_we", wb_we_o, 0);
    chk("rst_wb_adr", wb_adr_o, 0);
    chk("rst_wb_dat", wb_dat_o, 0);
    chk("rst_ack", lsu_ack_o, 0);
    chk("rst_err", lsu_err_o, 0);
    chk("rst_data", lsu_data_o, 0);
    rst_i = 1;
    @(posedge clk_i); #1;
    chk_en = 1;

    // Directed cases.
    run_access(32'h1003, 32'h0, 32'h80FF1234, 1, 0, 1, 0, 0, 0, 0, 0, 0, -1);  // LB, zero wait
    run_access(32'h2002, 32'h0, 32'h80FF1234, 1, 0, 0, 1, 0, 1, 0, 0, 0, -1);  // LHU
    run_access(32'h3001, 32'hAB, 32'h0, 0, 1, 1, 0, 0, 0, 1, 0, 0, -1);         // SB
    run_access(32'h4002, 32'h55, 32'h0, 0, 1, 0, 0, 1, 0, 0, 0, 0, -1);         // SW misaligned
    run_access(32'h5000, 32'h0, 32'h0, 1, 0, 0, 0, 1, 0, -1, 0, 0, -1);         // LW timeout
    run_access(32'h6000, 32'h0, 32'h12345678, 1, 0, 0, 0, 1, 0, 2, 1, 0, -1);   // LW bus error
    run_access(32'h6004, 32'h0, 32'hCAFEF00D, 1, 0, 0, 0, 1, 0, 0, 0, 3, -1);   // LW held by stall
    run_access(32'h6008, 32'h0, 32'h0BADBEEF, 1, 0, 0, 0, 1, 0, 3, 0, 0, 1);    // kill then ack
    run_access(32'h600C, 32'h0, 32'h0BADBEEF, 1, 0, 0, 0, 1, 0, 1, 0, 0, 1);    // kill with ack
    run_access(32'h7001, 32'h0, 32'h89ABCDEF, 1, 0, 1, 1, 1, 1, 0, 0, 0, -1);   // word priority
    run_access(32'h7002, 32'h1234BEEF, 32'h0, 1, 1, 0, 1, 0, 0, 0, 0, 0, -1);   // rd+wr is store

    // Asynchronous reset in the middle of a bus cycle.
    @(posedge clk_i); #1;
    lsu_addr_i = 32'h7000; lsu_mread_i = 1; lsu_mword_i = 1; lsu_mbyte_i = 0; lsu_mhw_i = 0;
    e_lcyc = 1; e_wbcyc = 0; e_ack = 0; e_adr = 32'h7000; e_sel = 4'hF; e_we = 0;
    @(posedge clk_i); #1;
    lsu_mread_i = 0; lsu_mword_i = 0;
    e_wbcyc = 1;
    @(posedge clk_i); #1;
    #2;
    chk_en = 0;
    rst_i = 0;
    #1;
    chk("async_rst_wb_cyc", wb_cyc_o, 0);
    chk("async_rst_wb_stb", wb_stb_o, 0);
    chk("async_rst_lsu_cyc", lsu_cyc_o, 0);
    chk("async_rst_ack", lsu_ack_o, 0);
    #3;
    rst_i = 1;
    set_idle();
    @(posedge clk_i); #1;
    chk_en = 1;
    repeat (2) @(posedge clk_i);
    #1;

    // Randomized accesses.
    for (int t = 0; t < 200; t++) begin
      op = $urandom % 8;
      sz = 3'($urandom % 8);
      if (sz == 3'd0) sz = 3'd1;
      r = $urandom % 20;
      resp_at = (r < 18) ? (r % 5) : -1;
      kr = $urandom % 10;
      kill_at = (kr == 0) ? -2 : ((kr == 1) ? int'($urandom % 4) : -1);
      run_access($urandom, $urandom, $urandom,
                 (op >= 1 && op <= 4) || op == 7, (op >= 5), sz[0], sz[1], sz[2],
                 1'($urandom % 2), resp_at, ($urandom % 5) == 0, $urandom % 4, kill_at);
    end

    @(posedge clk_i); #1;
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
